up_counter: RTL and testbench

UP_COUNTER -- requirements
Module: up_counter

---
 rtl/up_counter.sv | 85 ++++++++
 tb/tb_up_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/up_counter.sv
// Start/stop/load up-counter with terminal-count detection and optional auto-reload.
// Define UP_COUNTER_WRAPS_EN to add the saturating 8-bit reload counter output "wraps".
module up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done
`ifdef UP_COUNTER_WRAPS_EN
  ,
  output logic [7:0]       wraps
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             done_nxt;

  // Priority per cycle: stop, then load, then start, then increment/terminal check.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    if (stop) begin
      if (state == S_RUN) state_nxt = S_PAUSE;
    end else if (load) begin
      count_nxt = load_val;
    end else if (start && (state != S_RUN)) begin
      state_nxt = S_RUN;
      if (state != S_PAUSE) count_nxt = '0;
    end else if (state == S_RUN) begin
      if (count == limit) begin
        done_nxt = 1'b1;
        if (auto_reload) count_nxt = '0;
        else             state_nxt = S_DONE;
      end else begin
        count_nxt = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      running <= (state_nxt == S_RUN);
      done    <= done_nxt;
    end
  end

`ifdef UP_COUNTER_WRAPS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic wrap_hit, wrap_clr;
  assign wrap_hit = (state == S_RUN) && !stop && !load && (count == limit) && auto_reload;
  assign wrap_clr = !stop && !load && start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          wraps <= 8'd0;
    else if (wrap_clr) wraps <= 8'd0;
    else if (wrap_hit) wraps <= sat_inc(wraps);
  end
`endif

endmodule

// File: tb/tb_up_counter.sv
// Directed-sequence bench for up_counter (WIDTH=4) with an expected-value queue.
module tb_up_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, load = 1'b0, auto_reload = 1'b0;
  logic [3:0] load_val = '0, limit = '0;
  logic [3:0] count;
  logic       running, done;
`ifdef UP_COUNTER_WRAPS_EN
  logic [7:0] wraps;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] c;
    logic       r;
    logic       d;
  } exp_t;
  exp_t q[$];

  up_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .limit(limit), .auto_reload(auto_reload),
    .count(count), .running(running), .done(done)
`ifdef UP_COUNTER_WRAPS_EN
    , .wraps(wraps)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, queue the expectation, check after the rising edge.
  task automatic step(input logic s, input logic sp, input logic ld, input logic [3:0] lv,
                      input string tag, input logic [3:0] ec, input logic er, input logic ed);
    exp_t e;
    @(negedge clk);
    start = s; stop = sp; load = ld; load_val = lv;
    q.push_back('{c: ec, r: er, d: ed});
    @(posedge clk);
    #1;
    e = q.pop_front();
    cmp({tag, ".count"},   {4'd0, count},   {4'd0, e.c});
    cmp({tag, ".running"}, {7'd0, running}, {7'd0, e.r});
    cmp({tag, ".done"},    {7'd0, done},    {7'd0, e.d});
  endtask

  initial begin
    #3;
    cmp("rst.count", {4'd0, count}, 8'd0);
    cmp("rst.running", {7'd0, running}, 8'd0);
    cmp("rst.done", {7'd0, done}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single-shot count to limit 5
    limit = 4'd5; auto_reload = 1'b0;
    step(1, 0, 0, 0, "a.start", 4'd0, 1, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, "a.cnt", 4'(i), 1, 0);
    step(0, 0, 0, 0, "a.term", 4'd5, 0, 1);
    step(0, 0, 0, 0, "a.hold", 4'd5, 0, 0);

    // Auto-reload with limit 3
    limit = 4'd3; auto_reload = 1'b1;
    step(1, 0, 0, 0, "b.start", 4'd0, 1, 0);
`ifdef UP_COUNTER_WRAPS_EN
    cmp("b.wraps0", wraps, 8'd0);
`endif
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, "b.cnt", 4'(i), 1, 0);
      step(0, 0, 0, 0, "b.reload", 4'd0, 1, 1);
`ifdef UP_COUNTER_WRAPS_EN
      cmp("b.wraps", wraps, 8'(k + 1));
`endif
    end

    // Pause and resume
    limit = 4'd9; auto_reload = 1'b0;
    step(0, 0, 0, 0, "c.cnt1", 4'd1, 1, 0);
    step(0, 0, 0, 0, "c.cnt2", 4'd2, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "c.pause", 4'd2, 0, 0);
    step(1, 0, 0, 0, "c.resume", 4'd2, 1, 0);
    step(0, 0, 0, 0, "c.cnt3", 4'd3, 1, 0);
    step(0, 0, 0, 0, "c.cnt4", 4'd4, 1, 0);

    // Load above limit wraps through zero before terminating
    limit = 4'd2;
    step(0, 0, 1, 4'd14, "d.load", 4'd14, 1, 0);
    step(0, 0, 0, 0, "d.cnt15", 4'd15, 1, 0);
    step(0, 0, 0, 0, "d.wrap0", 4'd0, 1, 0);
    step(0, 0, 0, 0, "d.cnt1", 4'd1, 1, 0);
    step(0, 0, 0, 0, "d.cnt2", 4'd2, 1, 0);
    step(0, 0, 0, 0, "d.term", 4'd2, 0, 1);
    step(1, 1, 0, 0, "d.both_done", 4'd2, 0, 0);
    step(1, 0, 0, 0, "d.restart", 4'd0, 1, 0);
    step(1, 1, 0, 0, "d.both_run", 4'd0, 0, 0);
    step(1, 0, 0, 0, "d.resume", 4'd0, 1, 0);

    // Asynchronous reset mid-count
    limit = 4'd12;
    for (int i = 1; i <= 7; i++) step(0, 0, 0, 0, "e.cnt", 4'(i), 1, 0);
    #2;
    rst = 1'b0;
    #1;
    cmp("e.async.count", {4'd0, count}, 8'd0);
    cmp("e.async.running", {7'd0, running}, 8'd0);
    cmp("e.async.done", {7'd0, done}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, "e.idle1", 4'd0, 0, 0);
    step(0, 0, 0, 0, "e.idle2", 4'd0, 0, 0);
    step(1, 0, 0, 0, "e.start", 4'd0, 1, 0);
    step(0, 0, 0, 0, "e.cnt1", 4'd1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
